// File: rtl/pipe_ctrl_unit.sv
// Pipelined RV32I control unit: decodes in D, carries the control word through E, M and W,
// and resolves conditional branches in E from the datapath flags.
module pipe_ctrl_unit #(
  parameter int WIDTH      = 32,
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      instr_d,
  input  logic                  flush_e,
  input  logic                  zero_e,
  input  logic                  lt_e,
  input  logic                  ltu_e,
  output logic [2:0]            imm_src_d,
  output logic                  illegal_d,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_e,
  output logic                  alu_src_e,
  output logic                  jump_src_e,
  output logic                  pc_src_e,
  output logic [1:0]            result_src_e,
  output logic                  reg_write_m,
  output logic                  mem_write_m,
  output logic [2:0]            funct3_m,
  output logic                  reg_write_w,
  output logic [1:0]            result_src_w
);

  typedef struct packed {
    logic                  reg_write;
    logic [1:0]            result_src;
    logic                  mem_write;
    logic                  jump;
    logic                  branch;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic                  alu_src;
    logic                  jump_src;
    logic [2:0]            funct3;
  } ctrl_t;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = ALU_CTRL_W'(0);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = ALU_CTRL_W'(2);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = ALU_CTRL_W'(3);
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = ALU_CTRL_W'(4);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = ALU_CTRL_W'(5);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = ALU_CTRL_W'(6);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = ALU_CTRL_W'(7);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = ALU_CTRL_W'(8);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = ALU_CTRL_W'(9);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [6:0]            w_op;
  logic [2:0]            w_f3;
  logic [6:0]            w_f7;
  logic                  w_unused;
  logic [ALU_CTRL_W-1:0] w_alu_fn;
  logic                  w_is_r;
  logic                  w_illegal;
  ctrl_t                 w_dec;
  ctrl_t                 w_ctrl_d;

  ctrl_t                 r_e;
  logic                  r_m_reg_write;
  logic [1:0]            r_m_result_src;
  logic                  r_m_mem_write;
  logic [2:0]            r_m_funct3;
  logic                  r_w_reg_write;
  logic [1:0]            r_w_result_src;

  assign w_op     = instr_d[6:0];
  assign w_f3     = instr_d[14:12];
  assign w_f7     = instr_d[31:25];
  assign w_unused = ^{instr_d[24:15], instr_d[11:7]};
  assign w_is_r   = (w_op == OP_R);

  // funct7[5] means sub only for R-type, but sra for both R and I shifts
  always_comb begin
    w_alu_fn = ALU_ADD;
    case (w_f3)
      3'b000:  w_alu_fn = (w_is_r && w_f7[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  w_alu_fn = ALU_SLL;
      3'b010:  w_alu_fn = ALU_SLT;
      3'b011:  w_alu_fn = ALU_SLTU;
      3'b100:  w_alu_fn = ALU_XOR;
      3'b101:  w_alu_fn = w_f7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  w_alu_fn = ALU_OR;
      default: w_alu_fn = ALU_AND;
    endcase
  end

  always_comb begin
    w_dec        = '0;
    w_dec.funct3 = w_f3;
    imm_src_d    = 3'b000;
    w_illegal    = 1'b0;
    case (w_op)
      OP_R: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_ctrl  = w_alu_fn;
        w_illegal = !((w_f7 == 7'h00) ||
                      (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
      end
      OP_I: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.alu_ctrl  = w_alu_fn;
        if (w_f3 == 3'b001)
          w_illegal = (w_f7 != 7'h00);
        else if (w_f3 == 3'b101)
          w_illegal = !(w_f7 == 7'h00 || w_f7 == 7'h20);
      end
      OP_LOAD: begin
        w_dec.reg_write  = 1'b1;
        w_dec.alu_src    = 1'b1;
        w_dec.result_src = 2'b01;
        w_illegal = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      end
      OP_STORE: begin
        w_dec.mem_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        imm_src_d       = 3'b001;
        w_illegal       = (w_f3 > 3'b010);
      end
      OP_BRANCH: begin
        w_dec.branch   = 1'b1;
        w_dec.alu_ctrl = ALU_SUB;
        imm_src_d      = 3'b010;
        w_illegal      = (w_f3 == 3'b010) || (w_f3 == 3'b011);
      end
      OP_JAL: begin
        w_dec.reg_write  = 1'b1;
        w_dec.jump       = 1'b1;
        w_dec.result_src = 2'b10;
        imm_src_d        = 3'b011;
      end
      OP_JALR: begin
        w_dec.reg_write  = 1'b1;
        w_dec.jump       = 1'b1;
        w_dec.jump_src   = 1'b1;
        w_dec.alu_src    = 1'b1;
        w_dec.result_src = 2'b10;
        w_illegal        = (w_f3 != 3'b000);
      end
      OP_LUI: begin
        w_dec.reg_write  = 1'b1;
        w_dec.result_src = 2'b11;
        imm_src_d        = 3'b100;
      end
      OP_AUIPC: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        imm_src_d       = 3'b100;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign illegal_d = w_illegal;
  assign w_ctrl_d  = w_illegal ? '0 : w_dec;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_e            <= '0;
      r_m_reg_write  <= 1'b0;
      r_m_result_src <= 2'b00;
      r_m_mem_write  <= 1'b0;
      r_m_funct3     <= 3'b000;
      r_w_reg_write  <= 1'b0;
      r_w_result_src <= 2'b00;
    end else begin
      r_e            <= flush_e ? '0 : w_ctrl_d;
      r_m_reg_write  <= r_e.reg_write;
      r_m_result_src <= r_e.result_src;
      r_m_mem_write  <= r_e.mem_write;
      r_m_funct3     <= r_e.funct3;
      r_w_reg_write  <= r_m_reg_write;
      r_w_result_src <= r_m_result_src;
    end
  end

  always_comb begin
    pc_src_e = r_e.jump;
    if (r_e.branch) begin
      case (r_e.funct3)
        3'b000:  pc_src_e = r_e.jump | zero_e;
        3'b001:  pc_src_e = r_e.jump | !zero_e;
        3'b100:  pc_src_e = r_e.jump | lt_e;
        3'b101:  pc_src_e = r_e.jump | !lt_e;
        3'b110:  pc_src_e = r_e.jump | ltu_e;
        3'b111:  pc_src_e = r_e.jump | !ltu_e;
        default: pc_src_e = r_e.jump;
      endcase
    end
  end

  assign alu_ctrl_e   = r_e.alu_ctrl;
  assign alu_src_e    = r_e.alu_src;
  assign jump_src_e   = r_e.jump_src;
  assign result_src_e = r_e.result_src;
  assign reg_write_m  = r_m_reg_write;
  assign mem_write_m  = r_m_mem_write;
  assign funct3_m     = r_m_funct3;
  assign reg_write_w  = r_w_reg_write;
  assign result_src_w = r_w_result_src;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: hand-computed control words checked at D, E, M and W.
module tb_pipe_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_d;
  logic        flush_e, zero_e, lt_e, ltu_e;
  logic [2:0]  imm_src_d;
  logic        illegal_d;
  logic [3:0]  alu_ctrl_e;
  logic        alu_src_e, jump_src_e, pc_src_e;
  logic [1:0]  result_src_e;
  logic        reg_write_m, mem_write_m;
  logic [2:0]  funct3_m;
  logic        reg_write_w;
  logic [1:0]  result_src_w;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] ADD   = 32'h002081B3;
  localparam logic [31:0] SUB   = 32'h40208133;
  localparam logic [31:0] SRAI  = 32'h4010D093;
  localparam logic [31:0] BNE   = 32'h00209463;
  localparam logic [31:0] BLTU  = 32'h0020E463;
  localparam logic [31:0] BGE   = 32'h0020D463;
  localparam logic [31:0] BBAD  = 32'h0020A463;
  localparam logic [31:0] LW    = 32'h0000A183;
  localparam logic [31:0] SW    = 32'h0030A023;
  localparam logic [31:0] JALR  = 32'h000080E7;
  localparam logic [31:0] JAL   = 32'h000000EF;
  localparam logic [31:0] ILL7F = 32'h0000007F;

  always #5 clk = ~clk;

  pipe_ctrl_unit dut (
    .clk(clk), .rst(rst), .instr_d(instr_d), .flush_e(flush_e),
    .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
    .imm_src_d(imm_src_d), .illegal_d(illegal_d),
    .alu_ctrl_e(alu_ctrl_e), .alu_src_e(alu_src_e), .jump_src_e(jump_src_e),
    .pc_src_e(pc_src_e), .result_src_e(result_src_e),
    .reg_write_m(reg_write_m), .mem_write_m(mem_write_m), .funct3_m(funct3_m),
    .reg_write_w(reg_write_w), .result_src_w(result_src_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; instr_d = NOP; flush_e = 1'b0;
    zero_e = 1'b0; lt_e = 1'b0; ltu_e = 1'b0;
    step(); step();
    check("rst alu_ctrl_e",   32'(alu_ctrl_e), 0);
    check("rst alu_src_e",    32'(alu_src_e), 0);
    check("rst jump_src_e",   32'(jump_src_e), 0);
    check("rst pc_src_e",     32'(pc_src_e), 0);
    check("rst result_src_e", 32'(result_src_e), 0);
    check("rst reg_write_m",  32'(reg_write_m), 0);
    check("rst mem_write_m",  32'(mem_write_m), 0);
    check("rst funct3_m",     32'(funct3_m), 0);
    check("rst reg_write_w",  32'(reg_write_w), 0);
    check("rst result_src_w", 32'(result_src_w), 0);

    // ADD through all stages, followed by SUB and SRAI
    rst = 1'b0; instr_d = ADD; #1;
    check("add illegal_d", 32'(illegal_d), 0);
    step();
    check("add alu_ctrl_e", 32'(alu_ctrl_e), 0);
    check("add alu_src_e",  32'(alu_src_e), 0);
    instr_d = SUB;
    step();
    check("add reg_write_m", 32'(reg_write_m), 1);
    check("sub alu_ctrl_e",  32'(alu_ctrl_e), 1);
    instr_d = SRAI;
    step();
    check("add reg_write_w",  32'(reg_write_w), 1);
    check("add result_src_w", 32'(result_src_w), 0);
    check("srai alu_ctrl_e",  32'(alu_ctrl_e), 9);
    check("srai alu_src_e",   32'(alu_src_e), 1);

    // BNE taken / not taken
    instr_d = BNE; #1;
    check("bne imm_src_d", 32'(imm_src_d), 3'b010);
    step();
    zero_e = 1'b0; #1;
    check("bne ne pc_src_e", 32'(pc_src_e), 1);
    zero_e = 1'b1; #1;
    check("bne eq pc_src_e", 32'(pc_src_e), 0);
    check("bne alu_ctrl_e",  32'(alu_ctrl_e), 1);
    zero_e = 1'b0;
    instr_d = BLTU;
    step();
    check("bne reg_write_m", 32'(reg_write_m), 0);
    check("bne mem_write_m", 32'(mem_write_m), 0);
    ltu_e = 1'b1; lt_e = 1'b0; #1;
    check("bltu pc_src_e", 32'(pc_src_e), 1);
    ltu_e = 1'b0; #1;
    check("bltu nt pc_src_e", 32'(pc_src_e), 0);
    instr_d = BGE;
    step();
    check("bne reg_write_w", 32'(reg_write_w), 0);
    lt_e = 1'b1; #1;
    check("bge lt pc_src_e", 32'(pc_src_e), 0);
    lt_e = 1'b0; #1;
    check("bge ge pc_src_e", 32'(pc_src_e), 1);

    // Branch funct3 010 is illegal
    instr_d = BBAD; #1;
    check("bbad illegal_d", 32'(illegal_d), 1);

    // LW, then SW flushed on its way into E
    instr_d = LW; #1;
    check("lw illegal_d", 32'(illegal_d), 0);
    step();
    check("lw result_src_e", 32'(result_src_e), 2'b01);
    check("lw alu_src_e",    32'(alu_src_e), 1);
    instr_d = SW; flush_e = 1'b1; #1;
    check("sw imm_src_d", 32'(imm_src_d), 3'b001);
    step();
    check("flushed sw alu_src_e", 32'(alu_src_e), 0);
    check("lw reg_write_m",       32'(reg_write_m), 1);
    check("lw funct3_m",          32'(funct3_m), 3'b010);
    flush_e = 1'b0; instr_d = NOP;
    step();
    check("flushed sw mem_write_m", 32'(mem_write_m), 0);
    check("lw result_src_w",        32'(result_src_w), 2'b01);
    check("lw reg_write_w",         32'(reg_write_w), 1);

    // Unflushed SW does write memory in M
    instr_d = SW;
    step();
    instr_d = NOP;
    step();
    check("sw mem_write_m", 32'(mem_write_m), 1);
    check("sw funct3_m",    32'(funct3_m), 3'b010);

    // JALR
    instr_d = JALR;
    step();
    check("jalr pc_src_e",     32'(pc_src_e), 1);
    check("jalr jump_src_e",   32'(jump_src_e), 1);
    check("jalr result_src_e", 32'(result_src_e), 2'b10);
    instr_d = NOP;
    step(); step();
    check("jalr result_src_w", 32'(result_src_w), 2'b10);

    // Opcode 0x7F: illegal, bubble into E
    instr_d = ILL7F; #1;
    check("ill illegal_d", 32'(illegal_d), 1);
    step();
    check("ill alu_src_e",    32'(alu_src_e), 0);
    check("ill result_src_e", 32'(result_src_e), 0);
    check("ill pc_src_e",     32'(pc_src_e), 0);
    instr_d = NOP;
    step();
    check("ill reg_write_m", 32'(reg_write_m), 0);

    // Reset while JAL is in E, with flush also asserted
    instr_d = JAL; #1;
    check("jal imm_src_d", 32'(imm_src_d), 3'b011);
    step();
    check("jal pc_src_e",   32'(pc_src_e), 1);
    check("jal jump_src_e", 32'(jump_src_e), 0);
    rst = 1'b1; flush_e = 1'b1;
    step();
    check("rst jal pc_src_e",    32'(pc_src_e), 0);
    check("rst jal reg_write_m", 32'(reg_write_m), 0);
    check("rst jal reg_write_w", 32'(reg_write_w), 0);
    rst = 1'b0; flush_e = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
